// File: rtl/rf_writeback_pkg.sv
// Shared widths and the {dest, data} write-back entry used by the MEM FIFO and the write arbiter.
package rf_writeback_pkg;

   localparam int DATA_W     = 28;
   localparam int ADDR_W     = 4;
   localparam int NREG       = 1 << ADDR_W;
   localparam int FIFO_DEPTH = 4;
   localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;

   typedef struct packed {
      logic [ADDR_W-1:0] dest;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Synchronous FIFO of write-back entries. Data is readable at the head the cycle after the push.
// A push while full or a pop while empty is ignored. Full does not consider a same-cycle pop.
module rf_wb_fifo
   import rf_writeback_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  wb_entry_t        push_dat_i,
   input  logic             pop_i,
   output wb_entry_t        head_o,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o,
   output logic             empty_o
);

   wb_entry_t        mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
   end

endmodule

// File: rtl/rf_writeback.sv
// Register-file write port controller: ALU (priority, 1 cycle) and buffered MEM results, plus busy scoreboard.
// MEM results reach rf_* at least 2 cycles after handshake; mem_ready drops only when the FIFO is full.
module rf_writeback
   import rf_writeback_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  issue_valid,
   input  logic [ADDR_W-1:0]     issue_dest,
   input  logic                  alu_valid,
   input  logic [ADDR_W-1:0]     alu_dest,
   input  logic [DATA_W-1:0]     alu_data,
   input  logic                  mem_valid,
   input  logic [ADDR_W-1:0]     mem_dest,
   input  logic [DATA_W-1:0]     mem_data,
   output logic                  mem_ready,
   input  logic [ADDR_W-1:0]     chk_rs0,
   input  logic [ADDR_W-1:0]     chk_rs1,
   output logic                  hazard0,
   output logic                  hazard1,
   output logic                  rf_wen,
   output logic [ADDR_W-1:0]     rf_dest_sel,
   output logic [DATA_W-1:0]     rf_data,
   output logic [NREG-1:0]       busy,
   output logic [FIFO_CNT_W-1:0] fifo_count
);

   wb_entry_t         alu_ent, mem_ent, head, sel_ent;
   logic              fifo_full, fifo_empty, pop, sel_vld;
   logic              wen_q, wen_d;
   logic [ADDR_W-1:0] dest_q, dest_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [NREG-1:0]   busy_q, busy_d;

   assign alu_ent   = '{dest: alu_dest, data: alu_data};
   assign mem_ent   = '{dest: mem_dest, data: mem_data};
   assign mem_ready = !fifo_full;

   rf_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (mem_valid),
      .push_dat_i (mem_ent),
      .pop_i      (pop),
      .head_o     (head),
      .count_o    (fifo_count),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty)
   );

   // R0 results are still consumed (ALU beat or FIFO pop) but never written.
   always_comb begin
      pop     = !alu_valid && !fifo_empty;
      sel_vld = alu_valid || !fifo_empty;
      sel_ent = alu_valid ? alu_ent : head;
      wen_d   = sel_vld && (sel_ent.dest != '0);
      dest_d  = wen_d ? sel_ent.dest : dest_q;
      data_d  = wen_d ? sel_ent.data : data_q;

      busy_d = busy_q;
      if (wen_d)       busy_d[sel_ent.dest] = 1'b0;
      if (issue_valid) busy_d[issue_dest]   = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wen_q  <= 1'b0;
         dest_q <= '0;
         data_q <= '0;
         busy_q <= '0;
      end else begin
         wen_q  <= wen_d;
         dest_q <= dest_d;
         data_q <= data_d;
         busy_q <= busy_d;
      end
   end

   assign rf_wen      = wen_q;
   assign rf_dest_sel = dest_q;
   assign rf_data     = data_q;
   assign busy        = busy_q;
   assign hazard0     = busy_q[chk_rs0];
   assign hazard1     = busy_q[chk_rs1];

endmodule

// File: tb/tb_rf_writeback.sv
// Directed bench for rf_writeback: ALU writes expected one cycle after the beat, MEM writes in handshake order.
module tb_rf_writeback;
   import rf_writeback_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  issue_valid = 1'b0;
   logic [ADDR_W-1:0]     issue_dest = '0;
   logic                  alu_valid = 1'b0;
   logic [ADDR_W-1:0]     alu_dest = '0;
   logic [DATA_W-1:0]     alu_data = '0;
   logic                  mem_valid = 1'b0;
   logic [ADDR_W-1:0]     mem_dest = '0;
   logic [DATA_W-1:0]     mem_data = '0;
   logic                  mem_ready;
   logic [ADDR_W-1:0]     chk_rs0 = '0;
   logic [ADDR_W-1:0]     chk_rs1 = '0;
   logic                  hazard0, hazard1;
   logic                  rf_wen;
   logic [ADDR_W-1:0]     rf_dest_sel;
   logic [DATA_W-1:0]     rf_data;
   logic [NREG-1:0]       busy;
   logic [FIFO_CNT_W-1:0] fifo_count;

   int n_cmp = 0;
   int n_err = 0;

   wb_entry_t         mem_exp_q[$];
   logic              exp_alu_vld = 1'b0;
   logic [ADDR_W-1:0] exp_alu_dest = '0;
   logic [DATA_W-1:0] exp_alu_data = '0;

   rf_writeback dut (
      .clk(clk), .rst(rst),
      .issue_valid(issue_valid), .issue_dest(issue_dest),
      .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_data(mem_data), .mem_ready(mem_ready),
      .chk_rs0(chk_rs0), .chk_rs1(chk_rs1), .hazard0(hazard0), .hazard1(hazard1),
      .rf_wen(rf_wen), .rf_dest_sel(rf_dest_sel), .rf_data(rf_data),
      .busy(busy), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard producer: record accepted results at the edge they are taken.
   always @(posedge clk) begin
      if (rst) begin
         mem_exp_q.delete();
         exp_alu_vld <= 1'b0;
      end else begin
         exp_alu_vld  <= alu_valid && (alu_dest != '0);
         exp_alu_dest <= alu_dest;
         exp_alu_data <= alu_data;
         if (mem_valid && mem_ready && (mem_dest != '0))
            mem_exp_q.push_back('{dest: mem_dest, data: mem_data});
      end
   end

   // Scoreboard consumer: ALU write must land now; otherwise any write is the oldest MEM result.
   always @(negedge clk) begin
      wb_entry_t e;
      if (exp_alu_vld) begin
         chk("sb_alu_wen", 64'(rf_wen), 64'd1);
         chk("sb_alu_dest", 64'(rf_dest_sel), 64'(exp_alu_dest));
         chk("sb_alu_data", 64'(rf_data), 64'(exp_alu_data));
      end else if (rf_wen === 1'b1) begin
         if (mem_exp_q.size() == 0) begin
            chk("sb_unexpected_wen", 64'(rf_dest_sel), 64'hDEAD);
         end else begin
            e = mem_exp_q.pop_front();
            chk("sb_mem_dest", 64'(rf_dest_sel), 64'(e.dest));
            chk("sb_mem_data", 64'(rf_data), 64'(e.data));
         end
      end
   end

   initial begin
      int  idx;
      logic hs;

      // Reset and idle
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("rst_wen", 64'(rf_wen), 64'd0);
      chk("rst_busy", 64'(busy), 64'h0000);
      chk("rst_mem_ready", 64'(mem_ready), 64'd1);
      chk("rst_fifo_count", 64'(fifo_count), 64'd0);
      chk("rst_dest", 64'(rf_dest_sel), 64'd0);
      chk("rst_data", 64'(rf_data), 64'd0);

      // Issue to R5, then ALU result to R5
      chk_rs0 = 4'd5; chk_rs1 = 4'd3;
      issue_valid = 1'b1; issue_dest = 4'd5;
      tick();
      issue_valid = 1'b0;
      chk("issue_busy", 64'(busy), 64'h0020);
      chk("issue_hazard0", 64'(hazard0), 64'd1);
      chk("issue_hazard1_clear", 64'(hazard1), 64'd0);
      alu_valid = 1'b1; alu_dest = 4'd5; alu_data = 28'h1234567;
      tick();
      alu_valid = 1'b0;
      chk("alu_wen", 64'(rf_wen), 64'd1);
      chk("alu_dest", 64'(rf_dest_sel), 64'd5);
      chk("alu_data", 64'(rf_data), 64'h1234567);
      chk("alu_busy_clear", 64'(busy), 64'h0000);
      chk("alu_hazard0_clear", 64'(hazard0), 64'd0);
      tick();
      chk("alu_wen_drop", 64'(rf_wen), 64'd0);
      chk("alu_dest_hold", 64'(rf_dest_sel), 64'd5);

      // ALU and MEM on the same cycle: ALU first, MEM next
      alu_valid = 1'b1; alu_dest = 4'd3; alu_data = 28'h0000333;
      mem_valid = 1'b1; mem_dest = 4'd7; mem_data = 28'h0FEDCBA;
      tick();
      alu_valid = 1'b0; mem_valid = 1'b0;
      chk("both_alu_dest", 64'(rf_dest_sel), 64'd3);
      chk("both_fifo_count", 64'(fifo_count), 64'd1);
      tick();
      chk("both_mem_wen", 64'(rf_wen), 64'd1);
      chk("both_mem_dest", 64'(rf_dest_sel), 64'd7);
      chk("both_mem_data", 64'(rf_data), 64'h0FEDCBA);
      chk("both_fifo_empty", 64'(fifo_count), 64'd0);
      tick();
      chk("both_idle", 64'(rf_wen), 64'd0);

      // ALU busy for 6 cycles while MEM offers 5 entries
      idx = 0;
      for (int c = 0; c < 11; c++) begin
         alu_valid = (c < 6);
         alu_dest  = ADDR_W'(c + 1);
         alu_data  = DATA_W'(28'h00A0000 + c);
         mem_valid = (idx < 5);
         mem_dest  = ADDR_W'(8 + idx);
         mem_data  = DATA_W'(28'h0B00000 + idx);
         hs = mem_valid && mem_ready;
         tick();
         if (hs) idx++;
         case (c)
            3: begin
               chk("fill_count4", 64'(fifo_count), 64'd4);
               chk("fill_ready0", 64'(mem_ready), 64'd0);
            end
            5: begin
               chk("fill_hold_count", 64'(fifo_count), 64'd4);
               chk("fill_accepted", 64'(idx), 64'd4);
            end
            6: begin
               chk("drain0_dest", 64'(rf_dest_sel), 64'd8);
               chk("drain0_count_no_bypass", 64'(fifo_count), 64'd3);
            end
            7: begin
               chk("drain1_dest", 64'(rf_dest_sel), 64'd9);
               chk("drain1_count", 64'(fifo_count), 64'd3);
               chk("fifth_accepted", 64'(idx), 64'd5);
            end
            8: chk("drain2_dest", 64'(rf_dest_sel), 64'd10);
            9: chk("drain3_dest", 64'(rf_dest_sel), 64'd11);
            10: begin
               chk("drain4_dest", 64'(rf_dest_sel), 64'd12);
               chk("drain4_wen", 64'(rf_wen), 64'd1);
               chk("drain_empty", 64'(fifo_count), 64'd0);
            end
            default: ;
         endcase
      end
      mem_valid = 1'b0;
      tick();
      chk("drain_idle", 64'(rf_wen), 64'd0);

      // R0 writes and issues are ignored
      chk_rs0 = 4'd0;
      alu_valid = 1'b1; alu_dest = 4'd0; alu_data = 28'h00ABCDE;
      issue_valid = 1'b1; issue_dest = 4'd0;
      tick();
      alu_valid = 1'b0; issue_valid = 1'b0;
      chk("r0_wen", 64'(rf_wen), 64'd0);
      chk("r0_busy", 64'(busy), 64'h0000);
      chk("r0_hazard0", 64'(hazard0), 64'd0);

      // Reset with FIFO holding 3 entries and R9 busy
      for (int c = 0; c < 3; c++) begin
         alu_valid   = 1'b1; alu_dest = 4'd1; alu_data = DATA_W'(c);
         mem_valid   = 1'b1; mem_dest = ADDR_W'(2 + 2 * c); mem_data = DATA_W'(28'h0C00000 + c);
         issue_valid = (c == 0); issue_dest = 4'd9;
         tick();
      end
      alu_valid = 1'b0; mem_valid = 1'b0; issue_valid = 1'b0;
      chk("prerst_count", 64'(fifo_count), 64'd3);
      chk("prerst_busy", 64'(busy), 64'h0200);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst2_count", 64'(fifo_count), 64'd0);
      chk("rst2_busy", 64'(busy), 64'h0000);
      chk("rst2_wen", 64'(rf_wen), 64'd0);
      chk("rst2_ready", 64'(mem_ready), 64'd1);
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("rst2_no_stale", 64'(rf_wen), 64'd0);
      end
      chk("sb_mem_left", 64'(mem_exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
